// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt entry sequencer: state encoding and defaults.
// INT_FLAG_SAVE_EN adds the PUSH_FLAGS state (flags pushed as a third stack word).
package interrupt_sequencer_pkg;

  localparam int FLAG_WIDTH = 3;
  localparam logic [15:0] VECTOR_ADDR_DEFAULT = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_SAFE  = 3'd1,
    ST_FLUSH      = 3'd2,
    ST_PUSH_HI    = 3'd3,
    ST_PUSH_LO    = 3'd4,
`ifdef INT_FLAG_SAVE_EN
    ST_PUSH_FLAGS = 3'd5,
`endif
    ST_READ_VEC   = 3'd6,
    ST_LOAD_PC    = 3'd7
  } state_e;

endpackage

// File: rtl/interrupt_sequencer.sv
// Hardware interrupt entry sequencer: waits for a safe boundary, flushes, pushes the
// return PC (and flags when INT_FLAG_SAVE_EN is defined), then loads the vector into the PC.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int                    PC_WIDTH    = 32,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] VECTOR_ADDR = VECTOR_ADDR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  int_req,
  input  logic                  imm_pending,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   pc_in,
  input  logic [FLAG_WIDTH-1:0] flags_in,
  input  logic                  stack_ack,
  input  logic                  vec_valid,
  input  logic [DATA_WIDTH-1:0] vec_data,
  output logic                  int_to_cu,
  output logic                  stall_fetch,
  output logic                  flush_fd,
  output logic                  stack_push,
  output logic [DATA_WIDTH-1:0] stack_data,
  output logic                  vec_read,
  output logic [DATA_WIDTH-1:0] vec_addr,
  output logic                  pc_load,
  output logic [PC_WIDTH-1:0]   pc_load_value,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [PC_WIDTH-1:0]   ret_pc_q, ret_pc_d;
  logic [DATA_WIDTH-1:0] vec_q, vec_d;
  logic                  safe;

`ifdef INT_FLAG_SAVE_EN
  logic [FLAG_WIDTH-1:0] flags_q, flags_d;
`else
  logic unused_flags;
  assign unused_flags = ^flags_in;
`endif

  assign safe = !imm_pending && !branch_taken;

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ret_pc_d  = ret_pc_q;
    vec_d     = vec_q;
`ifdef INT_FLAG_SAVE_EN
    flags_d   = flags_q;
`endif
    // WAIT_SAFE already owns the request that brought us here.
    if (int_req && state_q != ST_IDLE && state_q != ST_WAIT_SAFE) pending_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (int_req || pending_q) begin
          pending_d = 1'b0;
          state_d   = safe ? ST_FLUSH : ST_WAIT_SAFE;
        end
      end
      ST_WAIT_SAFE: if (safe) state_d = ST_FLUSH;
      ST_FLUSH: begin
        ret_pc_d = pc_in;
`ifdef INT_FLAG_SAVE_EN
        flags_d  = flags_in;
`endif
        state_d  = ST_PUSH_HI;
      end
      ST_PUSH_HI: if (stack_ack) state_d = ST_PUSH_LO;
`ifdef INT_FLAG_SAVE_EN
      ST_PUSH_LO:    if (stack_ack) state_d = ST_PUSH_FLAGS;
      ST_PUSH_FLAGS: if (stack_ack) state_d = ST_READ_VEC;
`else
      ST_PUSH_LO:    if (stack_ack) state_d = ST_READ_VEC;
`endif
      ST_READ_VEC: begin
        if (vec_valid) begin
          vec_d   = vec_data;
          state_d = ST_LOAD_PC;
        end
      end
      ST_LOAD_PC: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  always_comb begin
    int_to_cu     = 1'b0;
    flush_fd      = 1'b0;
    stack_push    = 1'b0;
    stack_data    = '0;
    vec_read      = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = '0;
    case (state_q)
      ST_FLUSH: begin
        int_to_cu = 1'b1;
        flush_fd  = 1'b1;
      end
      ST_PUSH_HI: begin
        int_to_cu  = 1'b1;
        stack_push = 1'b1;
        stack_data = DATA_WIDTH'(ret_pc_q >> DATA_WIDTH);
      end
      ST_PUSH_LO: begin
        int_to_cu  = 1'b1;
        stack_push = 1'b1;
        stack_data = ret_pc_q[DATA_WIDTH-1:0];
      end
`ifdef INT_FLAG_SAVE_EN
      ST_PUSH_FLAGS: begin
        int_to_cu  = 1'b1;
        stack_push = 1'b1;
        stack_data = DATA_WIDTH'(flags_q);
      end
`endif
      ST_READ_VEC: begin
        int_to_cu = 1'b1;
        vec_read  = 1'b1;
      end
      ST_LOAD_PC: begin
        int_to_cu     = 1'b1;
        pc_load       = 1'b1;
        pc_load_value = PC_WIDTH'(vec_q);
      end
      default: ;
    endcase
    stall_fetch = int_to_cu;
    busy        = (state_q != ST_IDLE);
  end

  assign vec_addr = VECTOR_ADDR;

  // NOTE: sequential state uses non-blocking assignments only; these few capture
  // registers are reset too so an aborted sequence leaves nothing stale on the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      ret_pc_q  <= '0;
      vec_q     <= '0;
`ifdef INT_FLAG_SAVE_EN
      flags_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ret_pc_q  <= ret_pc_d;
      vec_q     <= vec_d;
`ifdef INT_FLAG_SAVE_EN
      flags_q   <= flags_d;
`endif
    end
  end

endmodule
